param_rand_matrix_gen: RTL and testbench

Parametrised test-matrix source for the matrix calculator. On `start_gen` it emits `count` matrices of `dim_m × dim_n` signed elements over a valid/ready stream, with row/column indices and last-element flags. Four fill modes are available: uniform random within `[elem_min_cfg, elem_max_cfg]`, zero, identity, and incrementing. It sits between config_manager, which supplies the range and mode, and the matrix storage writer, which applies backpressure.

---
 rtl/param_rand_matrix_gen.sv | 208 ++++++++++++++++++++
 tb/tb_param_rand_matrix_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_rand_matrix_gen.sv
// Streams a configurable number of dim_m x dim_n signed test matrices in row-major order.
// Fill modes: LFSR-driven uniform random in [min,max], zero, identity, incrementing.
`timescale 1ns/1ps
module param_rand_matrix_gen #(
    parameter int          DATA_W    = 8,
    parameter int          MAX_DIM   = 5,
    parameter int          MAX_COUNT = 10,
    parameter logic [15:0] SEED      = 16'hACE1,
    localparam int         DIM_W     = $clog2(MAX_DIM + 1),
    localparam int         CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] elem_min_cfg,
    input  logic [DATA_W-1:0] elem_max_cfg,
    input  logic [1:0]        mode,
    input  logic              start_gen,
    input  logic              abort,
    input  logic [DIM_W-1:0]  dim_m,
    input  logic [DIM_W-1:0]  dim_n,
    input  logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] out_data,
    output logic [DIM_W-1:0]  out_row,
    output logic [DIM_W-1:0]  out_col,
    output logic              out_last_elem,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              gen_done,
    output logic              gen_err
);

    typedef enum logic [1:0] {IDLE, CHECK, GEN, DONE} state_t;

    state_t                   state_q;
    logic signed [DATA_W-1:0] min_q, max_q;
    logic [1:0]               mode_q;
    logic [DIM_W-1:0]         m_q, n_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [15:0]              lfsr_q;
    logic signed [DATA_W-1:0] data_q;
    logic [DIM_W-1:0]         row_q, col_q;
    logic [CNT_W-1:0]         mat_q;
    logic [DATA_W:0]          inc_q;
    logic                     valid_q, last_elem_q, last_q, done_q, err_q;

    logic [15:0]              lfsr_adv, lfsr_use;
    logic [DATA_W:0]          rng, inc_step;
    logic [DIM_W-1:0]         row_d, col_d;
    logic [CNT_W-1:0]         mat_d;
    logic [DATA_W:0]          inc_d;
    logic signed [DATA_W-1:0] data_d;
    logic                     last_elem_d, last_d, cfg_bad;

    // Element value for one position; the random offset (lfsr*range)>>16 is always < range.
    function automatic logic signed [DATA_W-1:0] elem_value(
        input logic [1:0]               md,
        input logic [15:0]              lfsr,
        input logic [DIM_W-1:0]         row,
        input logic [DIM_W-1:0]         col,
        input logic [DATA_W:0]          inc,
        input logic signed [DATA_W-1:0] lo,
        input logic [DATA_W:0]          range_w
    );
        logic [DATA_W+16:0] prod;
        logic [DATA_W:0]    lo_x;
        logic [DATA_W:0]    sum;
        lo_x = {lo[DATA_W-1], lo};
        prod = {{(DATA_W+1){1'b0}}, lfsr} * {16'd0, range_w};
        case (md)
            2'd0:    sum = lo_x + prod[DATA_W+16:16];
            2'd1:    sum = '0;
            2'd2:    sum = (row == col) ? (DATA_W+1)'(1) : '0;
            default: sum = lo_x + inc;
        endcase
        return sum[DATA_W-1:0];
    endfunction

    assign rng = {max_q[DATA_W-1], max_q} - {min_q[DATA_W-1], min_q} + (DATA_W+1)'(1);

    assign cfg_bad = (min_q > max_q) || (m_q == '0) || (n_q == '0)
                   || (m_q > DIM_W'(MAX_DIM)) || (n_q > DIM_W'(MAX_DIM))
                   || (cnt_q == '0) || (cnt_q > CNT_W'(MAX_COUNT));

    // In CHECK the first element is built from position zero and the current LFSR;
    // in GEN the following element is built from the advanced position and LFSR.
    always_comb begin
        lfsr_adv = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        inc_step = (inc_q == rng - (DATA_W+1)'(1)) ? '0 : inc_q + (DATA_W+1)'(1);
        lfsr_use = lfsr_q;
        row_d    = '0;
        col_d    = '0;
        mat_d    = '0;
        inc_d    = '0;
        if (state_q == GEN) begin
            lfsr_use = lfsr_adv;
            if (col_q == n_q - DIM_W'(1)) begin
                if (row_q == m_q - DIM_W'(1)) begin
                    mat_d = mat_q + CNT_W'(1);
                end else begin
                    row_d = row_q + DIM_W'(1);
                    mat_d = mat_q;
                    inc_d = inc_step;
                end
            end else begin
                row_d = row_q;
                col_d = col_q + DIM_W'(1);
                mat_d = mat_q;
                inc_d = inc_step;
            end
        end
        data_d      = elem_value(mode_q, lfsr_use, row_d, col_d, inc_d, min_q, rng);
        last_elem_d = (row_d == m_q - DIM_W'(1)) && (col_d == n_q - DIM_W'(1));
        last_d      = last_elem_d && (mat_d == cnt_q - CNT_W'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            min_q       <= '0;
            max_q       <= '0;
            mode_q      <= '0;
            m_q         <= '0;
            n_q         <= '0;
            cnt_q       <= '0;
            lfsr_q      <= SEED;
            data_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            mat_q       <= '0;
            inc_q       <= '0;
            valid_q     <= 1'b0;
            last_elem_q <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_gen) begin
                            min_q   <= elem_min_cfg;
                            max_q   <= elem_max_cfg;
                            mode_q  <= mode;
                            m_q     <= dim_m;
                            n_q     <= dim_n;
                            cnt_q   <= count;
                            state_q <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (cfg_bad) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q     <= GEN;
                            valid_q     <= 1'b1;
                            data_q      <= data_d;
                            row_q       <= row_d;
                            col_q       <= col_d;
                            mat_q       <= mat_d;
                            inc_q       <= inc_d;
                            last_elem_q <= last_elem_d;
                            last_q      <= last_d;
                        end
                    end
                    GEN: begin
                        if (valid_q && out_ready) begin
                            lfsr_q <= lfsr_adv;
                            if (last_q) begin
                                valid_q <= 1'b0;
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                data_q      <= data_d;
                                row_q       <= row_d;
                                col_q       <= col_d;
                                mat_q       <= mat_d;
                                inc_q       <= inc_d;
                                last_elem_q <= last_elem_d;
                                last_q      <= last_d;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign out_data      = data_q;
    assign out_row       = row_q;
    assign out_col       = col_q;
    assign out_last_elem = last_elem_q;
    assign out_last      = last_q;
    assign out_valid     = valid_q;
    assign busy          = (state_q != IDLE);
    assign gen_done      = done_q;
    assign gen_err       = err_q;

endmodule

// File: tb/tb_param_rand_matrix_gen.sv
// Directed bench for param_rand_matrix_gen: random/identity/incrementing streams,
// backpressure, configuration errors, abort and asynchronous reset.
`timescale 1ns/1ps
module tb_param_rand_matrix_gen;

    localparam int DATA_W    = 8;
    localparam int MAX_DIM   = 5;
    localparam int MAX_COUNT = 10;
    localparam int DIM_W     = $clog2(MAX_DIM + 1);
    localparam int CNT_W     = $clog2(MAX_COUNT + 1);
    localparam logic [15:0] SEED = 16'hACE1;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] elem_min_cfg, elem_max_cfg;
    logic [1:0]        mode;
    logic              start_gen, abort;
    logic [DIM_W-1:0]  dim_m, dim_n;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] out_data;
    logic [DIM_W-1:0]  out_row, out_col;
    logic              out_last_elem, out_last, out_valid, out_ready;
    logic              busy, gen_done, gen_err;

    param_rand_matrix_gen #(
        .DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .MAX_COUNT(MAX_COUNT), .SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst),
        .elem_min_cfg(elem_min_cfg), .elem_max_cfg(elem_max_cfg),
        .mode(mode), .start_gen(start_gen), .abort(abort),
        .dim_m(dim_m), .dim_n(dim_n), .count(count),
        .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_last_elem(out_last_elem), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .gen_done(gen_done), .gen_err(gen_err)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] m_lfsr;
    int          got_q[$];
    int          seq1[$];

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic int rand_val(input logic [15:0] s, input int lo, input int hi);
        longint p;
        p = longint'(s) * longint'(hi - lo + 1);
        return lo + int'(p / 65536);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"},  32'(out_data), 0);
        chk({tag, "_row"},   32'(out_row), 0);
        chk({tag, "_col"},   32'(out_col), 0);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_lelem"}, 32'(out_last_elem), 0);
        chk({tag, "_last"},  32'(out_last), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(gen_done), 0);
        chk({tag, "_err"},   32'(gen_err), 0);
    endtask

    // intr_kind: 0 none, 1 abort at element intr_at, 2 async reset at element intr_at
    task automatic stream(input int md, input int lo, input int hi, input int m, input int n,
                          input int cnt, input int stall_at, input int stall_len,
                          input int poke_at, input int intr_kind, input int intr_at);
        int e;
        int ev, elast_e, elast;
        got_q.delete();
        mode = 2'(md); elem_min_cfg = DATA_W'(lo); elem_max_cfg = DATA_W'(hi);
        dim_m = DIM_W'(m); dim_n = DIM_W'(n); count = CNT_W'(cnt);
        out_ready = 1'b1; start_gen = 1'b1;
        tick();
        start_gen = 1'b0;
        chk("check_busy", 32'(busy), 1);
        chk("check_valid", 32'(out_valid), 0);
        tick();
        e = 0;
        for (int k = 0; k < cnt; k++) begin
            for (int r = 0; r < m; r++) begin
                for (int c = 0; c < n; c++) begin
                    case (md)
                        0:       ev = rand_val(m_lfsr, lo, hi);
                        1:       ev = 0;
                        2:       ev = (r == c) ? 1 : 0;
                        default: ev = lo + ((r * n + c) % (hi - lo + 1));
                    endcase
                    elast_e = (r == m - 1 && c == n - 1) ? 1 : 0;
                    elast   = (elast_e == 1 && k == cnt - 1) ? 1 : 0;
                    chk("elem_valid", 32'(out_valid), 1);
                    chk("elem_data", 32'($signed(out_data)), ev);
                    chk("elem_row", 32'(out_row), r);
                    chk("elem_col", 32'(out_col), c);
                    chk("elem_last_elem", 32'(out_last_elem), elast_e);
                    chk("elem_last", 32'(out_last), elast);
                    got_q.push_back(int'($signed(out_data)));
                    if (e == poke_at) begin
                        start_gen = 1'b1;
                        mode = 2'd1;
                        dim_m = DIM_W'(1);
                    end
                    if (e == stall_at) begin
                        out_ready = 1'b0;
                        for (int s = 0; s < stall_len; s++) begin
                            tick();
                            chk("stall_valid", 32'(out_valid), 1);
                            chk("stall_data", 32'($signed(out_data)), ev);
                            chk("stall_row", 32'(out_row), r);
                            chk("stall_col", 32'(out_col), c);
                            chk("stall_last", 32'(out_last), elast);
                        end
                        out_ready = 1'b1;
                    end
                    if (intr_kind == 1 && e == intr_at) begin
                        abort = 1'b1;
                        tick();
                        abort = 1'b0;
                        start_gen = 1'b0;
                        chk("abort_valid", 32'(out_valid), 0);
                        chk("abort_busy", 32'(busy), 0);
                        chk("abort_done", 32'(gen_done), 0);
                        return;
                    end
                    if (intr_kind == 2 && e == intr_at) begin
                        rst = 1'b1;
                        #1;
                        chk_reset_outputs("async_rst");
                        @(posedge clk);
                        #1;
                        rst = 1'b0;
                        return;
                    end
                    tick();
                    start_gen = 1'b0;
                    m_lfsr = lfsr_step(m_lfsr);
                    e++;
                end
            end
        end
        chk("done_pulse", 32'(gen_done), 1);
        chk("done_err", 32'(gen_err), 0);
        chk("done_valid", 32'(out_valid), 0);
        chk("done_busy", 32'(busy), 1);
        tick();
        chk("idle_done", 32'(gen_done), 0);
        chk("idle_busy", 32'(busy), 0);
    endtask

    task automatic err_req(input string tag, input int lo, input int hi, input int m, input int n, input int cnt);
        mode = 2'd0; elem_min_cfg = DATA_W'(lo); elem_max_cfg = DATA_W'(hi);
        dim_m = DIM_W'(m); dim_n = DIM_W'(n); count = CNT_W'(cnt);
        start_gen = 1'b1;
        tick();
        start_gen = 1'b0;
        chk({tag, "_t1_done"}, 32'(gen_done), 0);
        chk({tag, "_t1_valid"}, 32'(out_valid), 0);
        tick();
        chk({tag, "_t2_done"}, 32'(gen_done), 1);
        chk({tag, "_t2_err"}, 32'(gen_err), 1);
        chk({tag, "_t2_valid"}, 32'(out_valid), 0);
        tick();
        chk({tag, "_t3_done"}, 32'(gen_done), 0);
        chk({tag, "_t3_err"}, 32'(gen_err), 0);
        chk({tag, "_t3_busy"}, 32'(busy), 0);
        chk({tag, "_t3_valid"}, 32'(out_valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int id_exp[9];
        int inc_exp[4];
        id_exp  = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        inc_exp = '{0, 1, 2, 0};
        rst = 1'b1; start_gen = 1'b0; abort = 1'b0; out_ready = 1'b1;
        mode = 2'd0; elem_min_cfg = '0; elem_max_cfg = '0;
        dim_m = '0; dim_n = '0; count = '0;
        m_lfsr = SEED;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // random -3..3, 2x3, two matrices, no backpressure
        stream(0, -3, 3, 2, 3, 2, -1, 0, -1, 0, -1);
        seq1 = got_q;
        chk("run1_len", got_q.size(), 12);
        chk("run1_first", got_q[0], 1);
        foreach (got_q[i]) chk("run1_in_range", (got_q[i] >= -3 && got_q[i] <= 3) ? 1 : 0, 1);

        // same request with a 3-cycle stall and a start pulse plus config change while busy
        stream(0, -3, 3, 2, 3, 2, 4, 3, 7, 0, -1);

        stream(2, 0, 0, 3, 3, 1, -1, 0, -1, 0, -1);
        foreach (id_exp[i]) chk("identity_value", got_q[i], id_exp[i]);

        stream(3, 0, 2, 2, 2, 1, -1, 0, -1, 0, -1);
        foreach (inc_exp[i]) chk("incr_value", got_q[i], inc_exp[i]);

        err_req("err_minmax", 5, -5, 2, 2, 1);
        err_req("err_dim0", 0, 3, 0, 2, 1);
        err_req("err_count", 0, 3, 2, 2, MAX_COUNT + 1);

        // abort on the 4th element, then a fresh request continues the LFSR sequence
        stream(0, -8, 7, 4, 4, 1, -1, 0, -1, 1, 3);
        stream(0, -8, 7, 1, 3, 1, -1, 0, -1, 0, -1);

        // reset mid-stream, then the first request must replay from SEED
        stream(0, -3, 3, 2, 3, 2, -1, 0, -1, 2, 5);
        m_lfsr = SEED;
        tick();
        chk_reset_outputs("post_rst");
        stream(0, -3, 3, 2, 3, 2, -1, 0, -1, 0, -1);
        chk("replay_len", got_q.size(), 12);
        foreach (seq1[i]) chk("replay_value", got_q[i], seq1[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
